// File: rtl/local_inj_ctrl_pkg.sv
// Shared definitions for the local injection/ejection port controller:
// flit geometry and the starvation FSM state encoding.
package local_inj_ctrl_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int VALID_POS  = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_STARVE = 2'd2
    } inj_state_e;

endpackage

// File: rtl/local_inj_ctrl_fifo.sv
// Synchronous injection FIFO with wrap-bit pointers, registered occupancy and
// a zeroed head output while empty.
module local_inj_ctrl_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   occ_o,
    output logic [AW:0]   occ_next_o
);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count_q, count_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only observable once occupancy covers it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_o    = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign occ_o      = count_q;
    assign occ_next_o = count_d;

endmodule

// File: rtl/local_inj_ctrl.sv
// Local port sequencer: injection FIFO feeding port 4 of the inject/eject stage,
// starvation detection with a registered throttle request, and the eject register.
module local_inj_ctrl
    import local_inj_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = local_inj_ctrl_pkg::DATA_WIDTH,
    parameter int VALID_POS  = local_inj_ctrl_pkg::VALID_POS,
    parameter int DEPTH      = 4,
    parameter int STARVE_TH  = 8,
    parameter int CNT_W      = 4,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] ni_flit_i,
    input  logic                  ni_valid_i,
    output logic                  ni_ready_o,
    output logic [DATA_WIDTH-1:0] inj_flit_o,
    input  logic                  inj_grant_i,
    input  logic                  merge_local_i,
    input  logic [DATA_WIDTH-1:0] eject_flit_i,
    output logic [DATA_WIDTH-1:0] ej_flit_o,
    output logic                  ej_valid_o,
    output logic                  starve_o,
    output logic [AW:0]           occupancy_o,
    output inj_state_e            dbg_state_o
);

    inj_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  starve_q, starve_d;
    logic [DATA_WIDTH-1:0] ej_flit_q, ej_flit_d;
    logic                  ej_valid_q, ej_valid_d;
    logic                  full, empty, pop;
    logic [AW:0]           occ_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pop = !empty && (inj_grant_i || merge_local_i);

    local_inj_ctrl_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (ni_valid_i),
        .wdata_i    (ni_flit_i),
        .pop_i      (pop),
        .rdata_o    (inj_flit_o),
        .full_o     (full),
        .empty_o    (empty),
        .occ_o      (occupancy_o),
        .occ_next_o (occ_next)
    );

    // The wait count starts on the cycle after the head first appears (IDLE lag)
    // or after a pop, so the two starvation latencies differ by one edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = (occ_next == '0) ? ST_IDLE : ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT, ST_STARVE: begin
                if (pop) begin
                    cnt_d   = '0;
                    state_d = (occ_next == '0) ? ST_IDLE : ST_WAIT;
                end else if (!empty) begin
                    if (state_q == ST_WAIT && cnt_q == CNT_W'(STARVE_TH - 1)) state_d = ST_STARVE;
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        starve_d   = (state_d == ST_STARVE);
        ej_flit_d  = eject_flit_i;
        ej_valid_d = eject_flit_i[VALID_POS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            starve_q   <= 1'b0;
            ej_flit_q  <= '0;
            ej_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            ej_flit_q  <= ej_flit_d;
            ej_valid_q <= ej_valid_d;
        end
    end

    assign ni_ready_o  = !full;
    assign starve_o    = starve_q;
    assign ej_flit_o   = ej_flit_q;
    assign ej_valid_o  = ej_valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_local_inj_ctrl.sv
// Self-checking bench for local_inj_ctrl: queue-based reference model of the
// injection FIFO, starvation timing and eject register.
module tb_local_inj_ctrl;
    import local_inj_ctrl_pkg::*;

    localparam int DW    = local_inj_ctrl_pkg::DATA_WIDTH;
    localparam int VP    = local_inj_ctrl_pkg::VALID_POS;
    localparam int DEPTH = 4;
    localparam int TH    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] ni_flit_i = '0;
    logic          ni_valid_i = 1'b0;
    logic          ni_ready_o;
    logic [DW-1:0] inj_flit_o;
    logic          inj_grant_i = 1'b0;
    logic          merge_local_i = 1'b0;
    logic [DW-1:0] eject_flit_i = '0;
    logic [DW-1:0] ej_flit_o;
    logic          ej_valid_o;
    logic          starve_o;
    logic [2:0]    occupancy_o;
    inj_state_e    dbg_state_o;

    int n_vec  = 0;
    int n_fail = 0;

    // reference model
    logic [DW-1:0] exp_q[$];
    int            run_m = -1;
    logic [DW-1:0] ej_m = '0;

    local_inj_ctrl #(.DEPTH(DEPTH), .STARVE_TH(TH), .CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ni_flit_i     (ni_flit_i),
        .ni_valid_i    (ni_valid_i),
        .ni_ready_o    (ni_ready_o),
        .inj_flit_o    (inj_flit_o),
        .inj_grant_i   (inj_grant_i),
        .merge_local_i (merge_local_i),
        .eject_flit_i  (eject_flit_i),
        .ej_flit_o     (ej_flit_o),
        .ej_valid_o    (ej_valid_o),
        .starve_o      (starve_o),
        .occupancy_o   (occupancy_o),
        .dbg_state_o   (dbg_state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_flit();
        logic [DW-1:0] f;
        f     = DW'($urandom);
        f[VP] = 1'b1;
        return f;
    endfunction

    function automatic logic [DW-1:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : '0;
    endfunction

    // Starvation rule: a head waiting since arrival needs TH+1 ungranted edges,
    // one waiting since a pop needs TH.
    function automatic logic exp_starve();
        return (exp_q.size() > 0) && (run_m >= TH);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        run_m = -1;
        ej_m  = '0;
    endtask

    task automatic drive(input logic nv, input logic [DW-1:0] nf, input logic gr,
                         input logic mg, input logic [DW-1:0] ef);
        bit was_empty, do_push, do_pop;
        ni_valid_i    = nv;
        ni_flit_i     = nf;
        inj_grant_i   = gr;
        merge_local_i = mg;
        eject_flit_i  = ef;
        was_empty = (exp_q.size() == 0);
        do_push   = nv && (exp_q.size() < DEPTH);
        do_pop    = !was_empty && (gr || mg);
        @(posedge clk);
        #1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(nf);
        if (do_pop) run_m = 0;
        else if (was_empty) run_m = -1;
        else run_m++;
        ej_m = ef;
    endtask

    task automatic idle_inputs();
        ni_valid_i = 0; inj_grant_i = 0; merge_local_i = 0; eject_flit_i = '0; ni_flit_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_clear();
        #2;
        n_vec++;
        if (occupancy_o !== 3'd0 || ni_ready_o !== 1'b1 || inj_flit_o !== '0 ||
            starve_o !== 1'b0 || ej_valid_o !== 1'b0 || ej_flit_o !== '0) begin
            n_fail++;
            $display("FAIL reset_values: occ=%0d rdy=%b inj=%h starve=%b ejv=%b ej=%h, want 0 1 0 0 0 0",
                     occupancy_o, ni_ready_o, inj_flit_o, starve_o, ej_valid_o, ej_flit_o);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1, i[0], '0);
            n_vec++;
            if (occupancy_o !== 3'd0 || inj_flit_o !== '0 || ni_ready_o !== 1'b1 || starve_o !== 1'b0) begin
                n_fail++;
                $display("FAIL empty_grant: occ=%0d inj=%h rdy=%b starve=%b, want 0 0 1 0",
                         occupancy_o, inj_flit_o, ni_ready_o, starve_o);
            end
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] first;
        for (int i = 0; i < 5; i++) begin
            logic [DW-1:0] f;
            f = rand_flit();
            if (i == 0) first = f;
            drive(1'b1, f, 1'b0, 1'b0, '0);
            n_vec++;
            if (occupancy_o !== 3'(exp_q.size()) || ni_ready_o !== (exp_q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL fill_occ[%0d]: occ=%0d rdy=%b, want %0d %b", i, occupancy_o, ni_ready_o,
                         exp_q.size(), exp_q.size() < DEPTH);
            end
        end
        n_vec++;
        if (occupancy_o !== 3'd4 || ni_ready_o !== 1'b0 || inj_flit_o !== first) begin
            n_fail++;
            $display("FAIL fill_full: occ=%0d rdy=%b head=%h, want 4 0 %h", occupancy_o, ni_ready_o, inj_flit_o, first);
        end
        while (exp_q.size() > 0) begin
            logic [DW-1:0] want;
            want = exp_q[0];
            n_vec++;
            if (inj_flit_o !== want) begin
                n_fail++;
                $display("FAIL drain_order: head=%h want %h", inj_flit_o, want);
            end
            drive(1'b0, '0, 1'b1, 1'b0, '0);
        end
        n_vec++;
        if (occupancy_o !== 3'd0 || inj_flit_o !== '0) begin
            n_fail++;
            $display("FAIL drain_empty: occ=%0d inj=%h, want 0 0", occupancy_o, inj_flit_o);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, rand_flit(), 1'b0, 1'b0, '0);
        drive(1'b1, rand_flit(), 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            logic [DW-1:0] second;
            second = exp_q[1];
            drive(1'b1, rand_flit(), 1'b1, 1'b0, '0);
            n_vec++;
            if (occupancy_o !== 3'd2 || inj_flit_o !== second || inj_flit_o !== exp_head()) begin
                n_fail++;
                $display("FAIL push_pop[%0d]: occ=%0d head=%h, want 2 %h", i, occupancy_o, inj_flit_o, second);
            end
        end
        repeat (2) drive(1'b0, '0, 1'b1, 1'b0, '0);
    endtask

    task automatic test_starve();
        logic [DW-1:0] f;
        f = rand_flit();
        drive(1'b1, f, 1'b0, 1'b0, '0);
        for (int k = 1; k <= 11; k++) begin
            drive(1'b0, '0, 1'b0, 1'b0, '0);
            n_vec++;
            if (starve_o !== (k >= 9) || starve_o !== exp_starve()) begin
                n_fail++;
                $display("FAIL starve_edge[%0d]: starve=%b want %b", k, starve_o, k >= 9);
            end
        end
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        n_vec++;
        if (starve_o !== 1'b0 || occupancy_o !== 3'd0 || dbg_state_o !== ST_IDLE) begin
            n_fail++;
            $display("FAIL starve_release: starve=%b occ=%0d state=%0d, want 0 0 0",
                     starve_o, occupancy_o, dbg_state_o);
        end
    endtask

    task automatic test_merge_reset();
        logic [DW-1:0] second;
        drive(1'b1, rand_flit(), 1'b0, 1'b0, '0);
        drive(1'b1, rand_flit(), 1'b0, 1'b0, '0);
        second = exp_q[1];
        drive(1'b0, '0, 1'b1, 1'b1, '0);
        n_vec++;
        if (occupancy_o !== 3'd1 || inj_flit_o !== second) begin
            n_fail++;
            $display("FAIL merge_pop: occ=%0d head=%h, want 1 %h", occupancy_o, inj_flit_o, second);
        end
        drive(1'b1, rand_flit(), 1'b0, 1'b0, 16'h8abc);
        drive(1'b1, rand_flit(), 1'b0, 1'b0, 16'h8abc);
        n_vec++;
        if (occupancy_o !== 3'd3 || ej_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_occ: occ=%0d ejv=%b, want 3 1", occupancy_o, ej_valid_o);
        end
        idle_inputs();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_vec++;
        if (occupancy_o !== 3'd0 || inj_flit_o !== '0 || ej_flit_o !== '0 || ej_valid_o !== 1'b0 ||
            starve_o !== 1'b0 || ni_ready_o !== 1'b1 || dbg_state_o !== ST_IDLE) begin
            n_fail++;
            $display("FAIL async_reset: occ=%0d inj=%h ej=%h ejv=%b starve=%b rdy=%b, want 0 0 0 0 0 1",
                     occupancy_o, inj_flit_o, ej_flit_o, ej_valid_o, starve_o, ni_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_eject();
        for (int i = 0; i < 12; i++) begin
            logic [DW-1:0] ef;
            ef = (i == 3) ? '0 : DW'($urandom);
            drive(1'b0, '0, 1'b0, 1'b0, ef);
            n_vec++;
            if (ej_flit_o !== ef || ej_valid_o !== ef[VP]) begin
                n_fail++;
                $display("FAIL eject[%0d]: ej=%h ejv=%b, want %h %b", i, ej_flit_o, ej_valid_o, ef, ef[VP]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic nv, gr, mg;
            nv = ($urandom_range(0, 3) != 0);
            gr = ($urandom_range(0, 9) == 0);
            mg = ($urandom_range(0, 11) == 0);
            drive(nv, rand_flit(), gr, mg, DW'($urandom));
            n_vec++;
            if (occupancy_o !== 3'(exp_q.size()) || ni_ready_o !== (exp_q.size() < DEPTH) ||
                inj_flit_o !== exp_head() || starve_o !== exp_starve() ||
                ej_flit_o !== ej_m || ej_valid_o !== ej_m[VP]) begin
                n_fail++;
                $display("FAIL random[%0d]: occ=%0d rdy=%b inj=%h st=%b ej=%h, want %0d %b %h %b %h",
                         i, occupancy_o, ni_ready_o, inj_flit_o, starve_o, ej_flit_o,
                         exp_q.size(), exp_q.size() < DEPTH, exp_head(), exp_starve(), ej_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_starve();
        test_merge_reset();
        test_eject();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/local_inj_ctrl.md
Name: local_inj_ctrl

Overview:
- Sequences the local injection/ejection port of the bufferless multicast router.
- Buffers flits from the network interface (NI) in a small injection FIFO and presents the head flit to the local inject/eject stage as its port-4 input.
- Pops the head when the stage grants a channel or merges the local flit; detects injection starvation and raises a throttle request; registers the ejected flit toward the NI.

Parameters:
- DATA_WIDTH, `DATA_WIDTH: flit width.
- VALID_POS, `VALID_POS: bit index of the flit valid bit.
- DEPTH, 4: injection FIFO entries; power of 2, at least 2.
- STARVE_TH, 8: consecutive ungranted head cycles that trigger starvation.
- CNT_W, 4: starvation counter width; must satisfy 2^CNT_W > STARVE_TH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ni_flit_i  in  DATA_WIDTH  flit from NI.
- ni_valid_i  in  1  NI flit valid.
- ni_ready_o  out  1  FIFO can accept a flit.
- inj_flit_o  out  DATA_WIDTH  head flit to the local stage port-4 input; all-zero when the FIFO is empty.
- inj_grant_i  in  1  OR of the stage's four per-channel inject enables.
- merge_local_i  in  1  the stage merged the local flit (merge bit 4).
- eject_flit_i  in  DATA_WIDTH  ejected flit from the stage port-4 output.
- ej_flit_o  out  DATA_WIDTH  registered ejected flit to NI.
- ej_valid_o  out  1  ej_flit_o valid.
- starve_o  out  1  throttle request to the upstream routers.
- occupancy_o  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Pointers = 0, occupancy = 0, FSM = IDLE, starvation counter = 0.
  - ej_flit_o = 0, ej_valid_o = 0, starve_o = 0, ni_ready_o = 1, inj_flit_o = 0.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
  - full when occupancy == DEPTH; empty when occupancy == 0.
  - ni_ready_o = !full. It is registered-state only; it never depends on a same-cycle pop.
  - push = ni_valid_i && ni_ready_o.
  - pop = !empty && (inj_grant_i || merge_local_i).
  - Grant and merge asserted together cause a single pop.
  - Grant or merge while empty is ignored, with no underflow.
  - Simultaneous push and pop leaves occupancy unchanged; push and pop on the same entry are legal only when not empty.
  - inj_flit_o is combinational from the head entry. The forwarded valid bit equals !empty; a stored flit with valid=0 is still forwarded as stored.
  - Latency: a flit pushed in cycle N appears on inj_flit_o in cycle N+1 if the FIFO was empty.
- Starvation FSM (states IDLE, WAIT, STARVE):
  - IDLE: FIFO empty. Go to WAIT when the FIFO is non-empty.
  - WAIT: counter increments each cycle the head is present and not popped.
    - A pop clears the counter; go to IDLE if the FIFO becomes empty, else stay in WAIT.
    - When counter == STARVE_TH-1 and no pop, go to STARVE.
  - STARVE: starve_o = 1 as a registered output, asserted the cycle after the FSM enters STARVE.
    - On pop, clear the counter and deassert starve_o on the next edge; go to WAIT or IDLE by the post-pop occupancy.
    - The counter saturates; it never wraps.
  - Reset mid-operation returns to IDLE immediately; FIFO contents are discarded.
- Eject register:
  - Every cycle: ej_flit_o <= eject_flit_i; ej_valid_o <= eject_flit_i[VALID_POS].
  - Fixed one-cycle latency, no backpressure. The NI must sink one flit per cycle.
- occupancy_o is registered and reflects the state after the last edge.

Decomposition:
- Shared package/global header: DATA_WIDTH, VALID_POS, and the FSM state encoding (IDLE=2'd0, WAIT=2'd1, STARVE=2'd2).
- One natural sub-module: inj_fifo, a parameterised synchronous FIFO with occupancy output. The FSM, counter and eject register stay in the top level.

Test Plan:
- Reset/empty: hold rst_n=0 then release with no NI traffic -> inj_flit_o=0, ni_ready_o=1, starve_o=0, occupancy_o=0. Grant pulses cause no underflow; occupancy_o stays 0.
- Fill to full: 5 consecutive NI pushes with no grant, DEPTH=4 -> occupancy_o=4, ni_ready_o=0 after the 4th push, 5th flit not accepted. The head stays the 1st flit.
- Simultaneous push and pop at occupancy 2: ni_valid_i=1 and inj_grant_i=1 -> occupancy_o stays 2 and the head advances to the 2nd flit. Order is preserved over 8 flits, including pointer wrap.
- Starvation with STARVE_TH=8: one flit and no grant for 8 cycles -> starve_o rises on the 9th edge after the head appears. A grant on cycle 12 pops it and starve_o=0 on the next edge; the FSM returns to IDLE.
- Merge pop and async reset: merge_local_i=1 with inj_grant_i=0 pops the head exactly once. Assert rst_n low mid-cycle at occupancy 3 -> outputs zero immediately, occupancy_o=0.
- Eject path: eject_flit_i with valid=1 in cycle N -> ej_valid_o=1 and ej_flit_o equal to that flit in N+1. eject_flit_i=0 gives ej_valid_o=0.
